bpred_table_ctrl: RTL and testbench

- Controller for a table of 2-bit saturating branch-prediction counters shared between a lookup (fetch) requester and an update (resolve) requester.
- After reset it sequences a table-initialisation sweep, then serves lookups and updates concurrently with defined collision priority.
- Keeps a saturating misprediction statistic for the core's performance counters.

---
 rtl/bpred_table_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bpred_table_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_table_ctrl.sv
// bpred_table_ctrl
//   Controller for a table of 2-bit saturating branch-prediction counters.
//   After reset it sweeps INIT_VAL into every entry, then serves a lookup
//   port and an update port concurrently. A same-index lookup/update pair
//   accepted on the same edge predicts from the post-update value. A
//   saturating misprediction counter is kept for performance statistics.
//
//   Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_INIT | sweep writes INIT_VAL to entry[ptr]; requests ignored
//   ST_RUN  | lookups and updates accepted every cycle
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_lk_valid, i_lk_idx    lookup request / index
//   o_lk_ready              lookup accepted this cycle when valid
//   o_pred_valid            one-cycle pulse, prediction available
//   o_pred_taken            predicted direction, holds between pulses
//   i_up_valid, i_up_idx    update request / index
//   i_up_taken              resolved branch outcome
//   o_up_ready              update accepted this cycle when valid
//   o_mispredict            pulse: last accepted update was mispredicted
//   o_mispredict_cnt        saturating misprediction count
//   i_clr_stats             synchronous clear of o_mispredict_cnt
//   o_busy                  high while the init sweep is running
module bpred_table_ctrl #(
    parameter int          IDX_W    = 4,
    parameter int          CNT_W    = 8,
    parameter logic [1:0]  INIT_VAL = 2'b10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lk_valid,
    input  logic [IDX_W-1:0] i_lk_idx,
    output logic             o_lk_ready,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    input  logic             i_up_valid,
    input  logic [IDX_W-1:0] i_up_idx,
    input  logic             i_up_taken,
    output logic             o_up_ready,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_mispredict_cnt,
    input  logic             i_clr_stats,
    output logic             o_busy
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [1:0]       r_table [DEPTH];

    logic             r_pred_valid;
    logic             r_pred_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_cnt;

    logic             w_run;
    logic             w_lk_acc;
    logic             w_up_acc;
    logic [1:0]       w_up_old;
    logic [1:0]       w_up_new;
    logic             w_mis;
    logic [1:0]       w_lk_val;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_INIT;
        w_ptr_nxt   = '0;
        case (r_state)
            ST_INIT: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    assign w_run    = (r_state == ST_RUN);
    assign w_lk_acc = i_lk_valid & w_run;
    assign w_up_acc = i_up_valid & w_run;
    assign w_up_old = r_table[i_up_idx];

    always_comb begin
        w_up_new = w_up_old;
        if (i_up_taken) begin
            if (w_up_old != 2'b11) w_up_new = w_up_old + 2'b01;
        end else begin
            if (w_up_old != 2'b00) w_up_new = w_up_old - 2'b01;
        end
    end

    // Misprediction is judged against the value before this update.
    assign w_mis = w_up_acc & (w_up_old[1] != i_up_taken);

    // Write-first bypass: a same-edge update to the looked-up entry wins.
    assign w_lk_val = (w_up_acc && (i_up_idx == i_lk_idx)) ? w_up_new
                                                            : r_table[i_lk_idx];

    // Table storage has no reset; the sweep rewrites every entry.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_table[r_ptr] <= INIT_VAL;
        end else if (w_up_acc) begin
            r_table[i_up_idx] <= w_up_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_mispredict <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_pred_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_taken <= w_lk_val[1];
            end
            r_mispredict <= w_mis;
            // Clear wins over a same-cycle increment.
            if (i_clr_stats) begin
                r_cnt <= '0;
            end else if (w_mis && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy           = ~w_run;
    assign o_lk_ready       = w_run;
    assign o_up_ready       = w_run;
    assign o_pred_valid     = r_pred_valid;
    assign o_pred_taken     = r_pred_taken;
    assign o_mispredict     = r_mispredict;
    assign o_mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// Self-checking bench for bpred_table_ctrl: reset/sweep sequences, a
// hand-computed vector table, counter saturation, async reset cases and
// randomized traffic against a behavioural table model.
module tb_bpred_table_ctrl;

    localparam int IDX_W = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic             mispredict;
    logic [CNT_W-1:0] mispredict_cnt;
    logic             clr_stats;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    bpred_table_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_VAL(2'b10)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_lk_valid      (lk_valid),
        .i_lk_idx        (lk_idx),
        .o_lk_ready      (lk_ready),
        .o_pred_valid    (pred_valid),
        .o_pred_taken    (pred_taken),
        .i_up_valid      (up_valid),
        .i_up_idx        (up_idx),
        .i_up_taken      (up_taken),
        .o_up_ready      (up_ready),
        .o_mispredict    (mispredict),
        .o_mispredict_cnt(mispredict_cnt),
        .i_clr_stats     (clr_stats),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             lkv;
        logic [IDX_W-1:0] lki;
        logic             upv;
        logic [IDX_W-1:0] upi;
        logic             upt;
        logic             clr;
        logic             pv;
        logic             pt;
        logic             mis;
        int               cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic lkv, int lki, logic upv, int upi, logic upt,
                                logic clr, logic pv, logic pt, logic mis, int cnt);
        vec_t v;
        v.lkv = lkv; v.lki = IDX_W'(lki); v.upv = upv; v.upi = IDX_W'(upi);
        v.upt = upt; v.clr = clr; v.pv = pv; v.pt = pt; v.mis = mis; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lk_valid = 1'b0; lk_idx = '0; up_valid = 1'b0; up_idx = '0;
        up_taken = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     int'(busy), 1);
        chk({tag, "_lkrdy"},    int'(lk_ready), 0);
        chk({tag, "_uprdy"},    int'(up_ready), 0);
        chk({tag, "_pv"},       int'(pred_valid), 0);
        chk({tag, "_pt"},       int'(pred_taken), 0);
        chk({tag, "_mis"},      int'(mispredict), 0);
        chk({tag, "_cnt"},      int'(mispredict_cnt), 0);
    endtask

    // Sweep must hold busy for exactly 16 edges after release, without
    // reacting to any request the caller leaves asserted.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, "_sweep_busy"},  int'(busy), 1);
            chk({tag, "_sweep_lkrdy"}, int'(lk_ready), 0);
            chk({tag, "_sweep_pv"},    int'(pred_valid), 0);
            chk({tag, "_sweep_mis"},   int'(mispredict), 0);
            step();
        end
        chk({tag, "_run_busy"},  int'(busy), 0);
        chk({tag, "_run_lkrdy"}, int'(lk_ready), 1);
        chk({tag, "_run_uprdy"}, int'(up_ready), 1);
        chk({tag, "_run_pv"},    int'(pred_valid), 0);
        chk({tag, "_run_cnt"},   int'(mispredict_cnt), 0);
    endtask

    // Behavioural model: counters as plain integers 0..3.
    int   m_tbl[DEPTH];
    int   m_cnt;
    logic m_pt;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("por");
        step(); step();
        rst_n = 1'b1;

        // Requests during the sweep must be ignored.
        lk_valid = 1'b1; lk_idx = 4'd0;
        up_valid = 1'b1; up_idx = 4'd0; up_taken = 1'b0;
        sweep_check("init");
        idle_inputs();

        for (int i = 0; i < DEPTH; i++) begin
            lk_valid = 1'b1; lk_idx = IDX_W'(i);
            step();
            chk("lookup_all_pv", int'(pred_valid), 1);
            chk("lookup_all_pt", int'(pred_taken), 1);
        end
        idle_inputs();

        // lkv lki upv upi upt clr | pv pt mis cnt
        vecs[0]  = mk(0, 0, 1, 3, 0, 0,  0, 1, 1, 1);
        vecs[1]  = mk(0, 0, 1, 3, 0, 0,  0, 1, 0, 1);
        vecs[2]  = mk(1, 3, 0, 0, 0, 0,  1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 1, 3, 0, 0,  0, 0, 0, 1);
        vecs[4]  = mk(1, 3, 0, 0, 0, 0,  1, 0, 0, 1);
        vecs[5]  = mk(0, 0, 1, 5, 1, 0,  0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 5, 1, 0,  0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 1, 5, 1, 0,  0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 1, 5, 0, 0,  0, 0, 1, 2);
        vecs[9]  = mk(1, 5, 0, 0, 0, 0,  1, 1, 0, 2);
        vecs[10] = mk(1, 7, 1, 7, 0, 0,  1, 0, 1, 3);
        vecs[11] = mk(1, 8, 1, 7, 0, 0,  1, 1, 0, 3);
        vecs[12] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 3);
        vecs[13] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 0);

        for (int v = 0; v < 14; v++) begin
            lk_valid = vecs[v].lkv; lk_idx = vecs[v].lki;
            up_valid = vecs[v].upv; up_idx = vecs[v].upi;
            up_taken = vecs[v].upt; clr_stats = vecs[v].clr;
            step();
            chk($sformatf("vec%0d_pv", v),  int'(pred_valid), int'(vecs[v].pv));
            chk($sformatf("vec%0d_pt", v),  int'(pred_taken), int'(vecs[v].pt));
            chk($sformatf("vec%0d_mis", v), int'(mispredict), int'(vecs[v].mis));
            chk($sformatf("vec%0d_cnt", v), int'(mispredict_cnt), vecs[v].cnt);
        end
        idle_inputs();

        // Alternating NT/T on a weak entry mispredicts every time.
        for (int i = 0; i < 300; i++) begin
            up_valid = 1'b1; up_idx = 4'd0; up_taken = (i % 2 == 1);
            step();
            if (i == 254) chk("sat_reach", int'(mispredict_cnt), 255);
        end
        chk("sat_cnt", int'(mispredict_cnt), 255);
        chk("sat_mis", int'(mispredict), 1);
        up_valid = 1'b1; up_idx = 4'd0; up_taken = 1'b0; clr_stats = 1'b1;
        step();
        chk("clr_prio_cnt", int'(mispredict_cnt), 0);
        chk("clr_prio_mis", int'(mispredict), 1);
        idle_inputs();

        // Reset in the middle of the sweep (ptr = 9).
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midsweep");
        step();
        rst_n = 1'b1;
        sweep_check("resweep");
        lk_valid = 1'b1; lk_idx = 4'd3;
        step();
        chk("resweep_idx3_pt", int'(pred_taken), 1);

        // Reset in RUN with a lookup pending and stats nonzero.
        lk_valid = 1'b1; lk_idx = 4'd3;
        up_valid = 1'b1; up_idx = 4'd4; up_taken = 1'b0;
        step();
        chk("prerst_mis", int'(mispredict), 1);
        chk("prerst_cnt", int'(mispredict_cnt), 1);
        up_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("runrst");
        step();
        chk("runrst_hold_pv", int'(pred_valid), 0);
        step();
        rst_n = 1'b1;
        sweep_check("runrst");
        lk_valid = 1'b1; lk_idx = 4'd4;
        step();
        chk("runrst_idx4_pv", int'(pred_valid), 1);
        chk("runrst_idx4_pt", int'(pred_taken), 1);
        idle_inputs();

        // Randomized traffic against the model (all entries weak-T, cnt 0).
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 2;
        m_cnt = 0;
        m_pt  = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic e_pv;
            logic e_mis;
            int   old;
            lk_valid  = ($urandom_range(0, 3) != 0);
            lk_idx    = IDX_W'($urandom_range(0, 15));
            up_valid  = ($urandom_range(0, 2) != 0);
            up_idx    = (n % 3 == 0) ? lk_idx : IDX_W'($urandom_range(0, 15));
            up_taken  = $urandom_range(0, 1) == 1;
            clr_stats = ($urandom_range(0, 31) == 0);

            e_mis = 1'b0;
            if (up_valid) begin
                old   = m_tbl[up_idx];
                e_mis = ((old >= 2) != up_taken);
                m_tbl[up_idx] = up_taken ? ((old < 3) ? old + 1 : 3)
                                         : ((old > 0) ? old - 1 : 0);
            end
            if (clr_stats)                  m_cnt = 0;
            else if (e_mis && m_cnt < 255)  m_cnt = m_cnt + 1;
            e_pv = lk_valid;
            if (lk_valid) m_pt = (m_tbl[lk_idx] >= 2);

            step();
            chk("rnd_pv",  int'(pred_valid), int'(e_pv));
            chk("rnd_pt",  int'(pred_taken), int'(m_pt));
            chk("rnd_mis", int'(mispredict), int'(e_mis));
            chk("rnd_cnt", int'(mispredict_cnt), m_cnt);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
